// File: rtl/opcg_capture_ctrl.sv
// OPCG capture controller: holds the core ICG open in functional mode and
// emits a 1-4 cycle at-speed launch/capture burst per tester trigger in test mode.
module opcg_capture_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk1x,
    input  logic       reset_n,
    input  logic       test_mode,
    input  logic       scan_en,
    input  logic       opcg_trigger,
    input  logic [1:0] num_pulses,
    input  logic       pll_lock,
    output logic       clk_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SETTLE,
        PULSE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, nxt;
    logic [1:0]       scan_sync, trig_sync;
    logic             scan_en_s, trig_d, trig_rise;
    logic [1:0]       pcnt, pcnt_nxt;
    logic [CNT_W-1:0] scnt, scnt_nxt;
    logic             err_nxt;

    assign scan_en_s = scan_sync[1];

    // trig_rise is registered so the FSM acts three edges after the trigger is sampled
    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            scan_sync <= '0;
            trig_sync <= '0;
            trig_d    <= 1'b0;
            trig_rise <= 1'b0;
        end else begin
            scan_sync <= {scan_sync[0], scan_en};
            trig_sync <= {trig_sync[0], opcg_trigger};
            trig_d    <= trig_sync[1];
            trig_rise <= trig_sync[1] & ~trig_d;
        end
    end

    always_comb begin
        nxt      = state;
        pcnt_nxt = pcnt;
        scnt_nxt = scnt;
        err_nxt  = err;
        if (!test_mode) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        if (pll_lock) begin
                            nxt      = ARM;
                            pcnt_nxt = num_pulses;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (!scan_en_s) begin
                        nxt      = SETTLE;
                        scnt_nxt = SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (scnt == '0) nxt = PULSE;
                    else            scnt_nxt = scnt - 1'b1;
                end
                PULSE: begin
                    if (pcnt == '0) nxt = DONE;
                    else            pcnt_nxt = pcnt - 1'b1;
                end
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
            // Lock loss aborts any active burst without a done pulse
            if (!pll_lock && (state inside {ARM, SETTLE, PULSE})) begin
                nxt     = IDLE;
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pcnt   <= '0;
            scnt   <= '0;
            clk_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= nxt;
            pcnt   <= pcnt_nxt;
            scnt   <= scnt_nxt;
            clk_en <= !test_mode || (nxt == PULSE);
            busy   <= nxt inside {ARM, SETTLE, PULSE};
            done   <= (nxt == DONE);
            err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_opcg_capture_ctrl.sv
// Bench for opcg_capture_ctrl: edge-numbered burst predictions queued by the
// stimulus and checked by an independent clk_en/done monitor.
module tb_opcg_capture_ctrl;

    localparam int S = 4;

    logic       clk1x        = 1'b0;
    logic       reset_n      = 1'b0;
    logic       test_mode    = 1'b0;
    logic       scan_en      = 1'b0;
    logic       opcg_trigger = 1'b0;
    logic       pll_lock     = 1'b1;
    logic [1:0] num_pulses   = 2'd0;
    logic       clk_en, busy, done, err;

    opcg_capture_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk1x       (clk1x),
        .reset_n     (reset_n),
        .test_mode   (test_mode),
        .scan_en     (scan_en),
        .opcg_trigger(opcg_trigger),
        .num_pulses  (num_pulses),
        .pll_lock    (pll_lock),
        .clk_en      (clk_en),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk1x = ~clk1x;

    int cyc = 0;
    always @(posedge clk1x) cyc <= cyc + 1;

    typedef struct {
        int start;
        int len;
        bit dn;
        bit er;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   mon_en  = 1'b0;
    bit   err_exp = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    // Monitor: a clk_en run ending is the DUT's "output event"
    initial begin : monitor
        logic prev;
        int   rs;
        exp_t e;
        prev = 1'b0;
        rs   = 0;
        forever begin
            @(posedge clk1x);
            #1;
            if (mon_en) begin
                if (clk_en && !prev) begin
                    rs = cyc;
                    chk("busy_in_pulse", busy, 1);
                end else if (!clk_en && prev) begin
                    chk("burst_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("pulse_start", rs, e.start);
                        chk("pulse_len", cyc - rs, e.len);
                        chk("done_at_end", done, e.dn);
                        chk("busy_fall", busy, 0);
                        chk("err_at_end", err, e.er);
                    end
                end else if (!clk_en) begin
                    chk("stray_done", done, 0);
                end
            end
            prev = clk_en;
        end
    end

    task automatic pulse_reset();
        @(negedge clk1x);
        reset_n = 1'b0;
        #1;
        chk("rst_clk_en", clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk1x);
        reset_n = 1'b1;
        err_exp = 1'b0;
    endtask

    // One trigger transaction; all times are edge numbers at which inputs are sampled
    task automatic run_txn(input int np, input int hold_d, input int abort_j,
                           input bit lockbad, input bit second, input bit rescan);
        int   c, k, h, m, se, p, runlen, endc, k2, t;
        exp_t e;
        if (hold_d >= 0) begin
            scan_en = 1'b1;
            repeat (4) @(negedge clk1x);
        end
        @(negedge clk1x);
        c      = cyc;
        k      = c + 2;
        h      = int'($urandom_range(1, 2));
        m      = (hold_d >= 0) ? k + hold_d : 0;
        se     = (hold_d >= 0 && m + 2 > k + 4) ? m + 2 : k + 4;
        p      = se + S;
        runlen = (abort_j > 0) ? abort_j : np + 1;
        endc   = lockbad ? k + 6 : p + runlen + 3;
        k2     = (second && !lockbad) ? int'($urandom_range(k + h + 1, p + runlen - 3)) : -10;
        num_pulses = 2'(np);
        if (!lockbad) begin
            e.start = p;
            e.len   = runlen;
            e.dn    = (abort_j == 0);
            e.er    = (abort_j > 0) || err_exp;
            q.push_back(e);
        end
        do begin
            @(negedge clk1x);
            t = cyc;
            opcg_trigger = ((t + 1 >= k) && (t + 1 < k + h)) ||
                           ((t + 1 >= k2) && (t + 1 < k2 + 2));
            if (hold_d >= 0) scan_en = (t + 1 < m);
            if (rescan && !lockbad && (t + 1 > se)) scan_en = 1'b1;
            pll_lock = !((lockbad && (t + 1 >= k) && (t + 1 <= k + 4)) ||
                         ((abort_j > 0) && (t + 1 >= p + abort_j)));
            if (lockbad && t == k + 4) begin
                chk("lock_low_err", err, 1);
                chk("lock_low_busy", busy, 0);
            end
        end while (t < endc);
        opcg_trigger = 1'b0;
        scan_en      = 1'b0;
        pll_lock     = 1'b1;
        if (lockbad || abort_j > 0) err_exp = 1'b1;
        repeat (2) @(negedge clk1x);
    endtask

    task automatic settle_reset();
        int c, k, t;
        @(negedge clk1x);
        c = cyc;
        k = c + 2;
        num_pulses = 2'd2;
        do begin
            @(negedge clk1x);
            t = cyc;
            opcg_trigger = (t + 1 == k);
        end while (t < k + 5);
        chk("settle_busy", busy, 1);
        chk("settle_err_before", err, err_exp);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_clk_en", clk_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk1x);
        reset_n = 1'b1;
        err_exp = 1'b0;
        repeat (3) @(negedge clk1x);
    endtask

    initial begin : stim
        int np, hd, ab;
        repeat (3) @(negedge clk1x);
        chk("clk_en_in_reset", clk_en, 0);
        reset_n = 1'b1;
        @(posedge clk1x);
        #1 chk("func_clk_en_first_edge", clk_en, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk1x);
            opcg_trigger = (i >= 10 && i < 13);
            chk("func_clk_en", clk_en, 1);
            chk("func_busy", busy, 0);
            chk("func_done", done, 0);
            chk("func_err", err, 0);
        end
        test_mode = 1'b1;
        repeat (4) @(negedge clk1x);
        chk("idle_clk_en", clk_en, 0);
        mon_en = 1'b1;

        run_txn(1, -1, 0, 1'b0, 1'b0, 1'b0);
        run_txn(3, 20, 0, 1'b0, 1'b0, 1'b0);
        run_txn(3, -1, 2, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        run_txn(0, -1, 0, 1'b1, 1'b0, 1'b0);
        run_txn(3, -1, 0, 1'b0, 1'b1, 1'b1);
        settle_reset();
        run_txn(2, -1, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom % 7 == 0) pulse_reset();
            np = int'($urandom_range(0, 3));
            hd = ($urandom % 3 == 0) ? int'($urandom_range(0, 12)) : -1;
            ab = ($urandom % 5 == 0) ? int'($urandom_range(1, np + 1)) : 0;
            run_txn(np, hd, ab, ($urandom % 8 == 0), ($urandom % 4 == 0), ($urandom % 4 == 0));
        end

        repeat (5) @(negedge clk1x);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/opcg_capture_ctrl.md
# opcg_capture_ctrl

On-product clock-generation (OPCG) controller sitting directly downstream of the `pll` clock model in the DFT clocking path. It runs on `clk1x` and drives the enable of the integrated clock gate (ICG) that feeds the core.
- In functional mode it holds the gate open.
- In test mode it keeps the PLL clock gated during scan shift, then emits an exact burst of 1–4 at-speed launch/capture cycles after a tester trigger.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4 — gated cycles inserted between scan-enable deassertion and the first pulse; legal range 1–255.
- `CNT_W`, 8 — settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk1x` input 1 — PLL 1x clock; all state on its rising edge.
- `reset_n` input 1 — asynchronous active-low reset.
- `test_mode` input 1 — static DFT mode; 0 = functional.
- `scan_en` input 1 — tester scan enable, asynchronous; 2-flop synchronized internally to `scan_en_s`.
- `opcg_trigger` input 1 — tester capture request, asynchronous; 2-flop synchronized, rising-edge detected.
- `num_pulses` input 2 — pulse count minus 1 (0 → 1 pulse, 3 → 4 pulses); captured on trigger acceptance.
- `pll_lock` input 1 — PLL lock indicator, already synchronous to `clk1x`.
- `clk_en` output 1 — registered ICG enable.
- `busy` output 1 — registered; high in ARM, SETTLE and PULSE.
- `done` output 1 — registered one-cycle pulse at burst completion.
- `err` output 1 — registered, sticky; cleared only by reset.

## Operation
- Reset values: `clk_en`=0, `busy`=0, `done`=0, `err`=0, FSM in IDLE, synchronizers 0, pulse and settle counters 0.
- Functional (`test_mode`=0): FSM forced to IDLE; `clk_en`=1 from the first edge after reset release; trigger ignored.
- Test mode, IDLE: `clk_en`=0. On a trigger rise edge (`trig_rise`):
  - if `pll_lock`=1: capture `num_pulses` into `pcnt` and go to ARM;
  - if `pll_lock`=0: set `err` and stay in IDLE.
- ARM: wait while `scan_en_s`=1 (no timeout). When `scan_en_s`=0, load the settle counter with SETTLE_CYCLES−1 and go to SETTLE.
- SETTLE: decrement the counter each cycle; at 0, go to PULSE.
- PULSE: `clk_en`=1 every cycle in this state; `pcnt` decrements each cycle; leaving with `pcnt`=0 goes to DONE. Burst length is exactly `num_pulses`+1 cycles.
- DONE: `done`=1 for one cycle, `clk_en`=0, then IDLE.
- `trig_rise` outside IDLE is ignored; no queuing.
- `pll_lock` falling while in ARM, SETTLE or PULSE: next state is IDLE, `clk_en` is 0 on the next edge, `err` is set, and no `done` is generated.
- `test_mode` falling mid-operation: go to IDLE next edge, no `done`, `err` unchanged.
- `scan_en_s` rising during SETTLE or PULSE: ignored; the burst completes.
- `reset_n` assertion at any time: all outputs are 0 immediately (asynchronous).

## Timing
- `opcg_trigger` sampled high at edge k:
  - `trig_rise` asserts after edge k+2;
  - the FSM enters ARM at edge k+3.
- With `scan_en_s` already 0: ARM lasts 1 cycle, SETTLE lasts SETTLE_CYCLES cycles, PULSE lasts `num_pulses`+1 cycles, DONE lasts 1 cycle.
- `clk_en` is driven from the registered next state, so it is high exactly during the PULSE cycles. It is glitch-free because the ICG latches it on the low phase.
- `busy` rises with entry to ARM and falls on entry to DONE. `done` and the fall of `busy` happen on the same edge.
- Trigger-to-first-pulse latency (`scan_en` low, lock high): 3 + 1 + SETTLE_CYCLES edges.
- Minimum trigger spacing: one burst completion plus one IDLE cycle, because the edge detector requires the trigger to return low.

## Test plan
- Reset then `test_mode`=0 → `clk_en`=0 during reset, 1 on the first edge after release; `busy`/`done`/`err` stay 0 for 50 cycles.
- `test_mode`=1, `scan_en`=0, `num_pulses`=1, SETTLE_CYCLES=4, trigger at edge 10 → ARM at 13, `clk_en`=1 at cycles 18–19 only, `done` at 20, `busy` at 13–19.
- `num_pulses`=3 with `scan_en` held 1 until edge 30, trigger at 10 → FSM waits in ARM; exactly 4 `clk_en` cycles start 5 cycles after `scan_en_s` falls; one `done`.
- `pll_lock` dropped on the 2nd pulse cycle of a 4-pulse burst → `clk_en` is 0 the next edge, `err`=1 and stays 1, no `done`, back to IDLE.
- Trigger with `pll_lock`=0 → `err`=1, `busy` stays 0. A second trigger during PULSE → ignored; pulse count is unchanged.
- Assert `reset_n` mid-SETTLE → all outputs are 0 asynchronously. After release, a new trigger produces a normal burst with `err`=0.
